ieee488_source_hs: RTL and testbench

IEEE-488 source-handshake (talker/controller) engine that drives the PET-side bus into the shared multi-drive IEEE-488 model. It accepts command and data bytes on a valid/ready stream and runs the three-wire DAV/NRFD/NDAC handshake against the combined drive outputs, with settle timing, timeout, no-device detection and IFC abort. It is the stimulus stage directly upstream of the drive array in the PET core and in drive-level benches.

---
 rtl/ieee488_source_hs.sv | 195 +++++++++++++++++++
 tb/tb_ieee488_source_hs.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee488_source_hs.sv
// IEEE-488 source handshake engine: takes command/data bytes from a valid/ready
// stream and runs DAV/NRFD/NDAC against the wired-AND bus, with settle, timeout and IFC abort.
module ieee488_source_hs #(
    parameter int unsigned SETTLE_CYCLES  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_atn,
    input  logic       tx_eoi,
    input  logic       atn_release,
    output logic [7:0] ieee_data_o,
    output logic       ieee_atn_o,
    output logic       ieee_eoi_o,
    output logic       ieee_dav_o,
    input  logic       ieee_nrfd_i,
    input  logic       ieee_ndac_i,
    input  logic       ieee_ifc_i,
    output logic       done,
    output logic       err_timeout,
    output logic       err_nodev,
    output logic       busy
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_RFD,
        S_ASSERT_DAV,
        S_WAIT_DAC,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]    data_q, data_d;
    logic          eoi_q, eoi_d;
    logic          dav_q, dav_d;
    logic          atn_held_q, atn_held_d;
    logic          tx_ready_q, tx_ready_d;
    logic          done_q, done_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_nodev_q, err_nodev_d;
    logic [1:0]    nrfd_sync_q, ndac_sync_q, ifc_sync_q;
    logic          nrfd, ndac, ifc;

    assign nrfd = nrfd_sync_q[1];
    assign ndac = ndac_sync_q[1];
    assign ifc  = ifc_sync_q[1];

    // Saturating increment: the counter may sit at its maximum but never wraps to 0,
    // which keeps cnt_q == 0 a reliable "first cycle in state" marker.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        eoi_d         = eoi_q;
        dav_d         = dav_q;
        atn_held_d    = atn_held_q;
        done_d        = 1'b0;
        err_timeout_d = 1'b0;
        err_nodev_d   = 1'b0;

        if (!ifc) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            data_d     = '1;
            eoi_d      = 1'b1;
            dav_d      = 1'b1;
            atn_held_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        state_d    = S_SETUP;
                        cnt_d      = '0;
                        data_d     = ~tx_data;
                        eoi_d      = ~tx_eoi;
                        atn_held_d = tx_atn;
                    end else if (atn_release) begin
                        atn_held_d = 1'b0;
                    end
                end
                S_SETUP: begin
                    if (32'(cnt_q) >= SETTLE_CYCLES - 1) begin
                        state_d = S_WAIT_RFD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_WAIT_RFD: begin
                    if (cnt_q == '0 && nrfd && ndac) begin
                        state_d     = S_IDLE;
                        data_d      = '1;
                        eoi_d       = 1'b1;
                        dav_d       = 1'b1;
                        err_nodev_d = 1'b1;
                    end else if (nrfd) begin
                        state_d = S_ASSERT_DAV;
                        dav_d   = 1'b0;
                    end else if (32'(cnt_q) >= TIMEOUT_CYCLES - 1) begin
                        state_d       = S_IDLE;
                        data_d        = '1;
                        eoi_d         = 1'b1;
                        dav_d         = 1'b1;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_ASSERT_DAV: begin
                    state_d = S_WAIT_DAC;
                    cnt_d   = '0;
                end
                S_WAIT_DAC: begin
                    if (ndac) begin
                        state_d = S_RELEASE;
                        data_d  = '1;
                        eoi_d   = 1'b1;
                        dav_d   = 1'b1;
                        done_d  = 1'b1;
                    end else if (32'(cnt_q) >= TIMEOUT_CYCLES - 1) begin
                        state_d       = S_IDLE;
                        data_d        = '1;
                        eoi_d         = 1'b1;
                        dav_d         = 1'b1;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_RELEASE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        tx_ready_d = (state_d == S_IDLE) && ifc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nrfd_sync_q   <= 2'b11;
            ndac_sync_q   <= 2'b11;
            ifc_sync_q    <= 2'b11;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            data_q        <= '1;
            eoi_q         <= 1'b1;
            dav_q         <= 1'b1;
            atn_held_q    <= 1'b0;
            tx_ready_q    <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_nodev_q   <= 1'b0;
        end else begin
            nrfd_sync_q   <= {nrfd_sync_q[0], ieee_nrfd_i};
            ndac_sync_q   <= {ndac_sync_q[0], ieee_ndac_i};
            ifc_sync_q    <= {ifc_sync_q[0], ieee_ifc_i};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            eoi_q         <= eoi_d;
            dav_q         <= dav_d;
            atn_held_q    <= atn_held_d;
            tx_ready_q    <= tx_ready_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            err_nodev_q   <= err_nodev_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign ieee_data_o = data_q;
    assign ieee_eoi_o  = eoi_q;
    assign ieee_dav_o  = dav_q;
    assign ieee_atn_o  = ~atn_held_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign err_nodev   = err_nodev_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ieee488_source_hs.sv
// Bench for ieee488_source_hs: byte transactions against a scripted listener, with
// outcome and timing predicted from the handshake rules.
module tb_ieee488_source_hs;

    localparam int unsigned S = 32;
    localparam int unsigned T = 200;
    localparam int W = 1 + S;
    localparam int RES_DONE = 0;
    localparam int RES_TMO = 1;
    localparam int RES_NODEV = 2;

    logic       clk, reset_n;
    logic       tx_valid, tx_ready, tx_atn, tx_eoi, atn_release;
    logic [7:0] tx_data, ieee_data_o;
    logic       ieee_atn_o, ieee_eoi_o, ieee_dav_o;
    logic       ieee_nrfd_i, ieee_ndac_i, ieee_ifc_i;
    logic       done, err_timeout, err_nodev, busy;

    ieee488_source_hs #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_atn(tx_atn), .tx_eoi(tx_eoi), .atn_release(atn_release),
        .ieee_data_o(ieee_data_o), .ieee_atn_o(ieee_atn_o),
        .ieee_eoi_o(ieee_eoi_o), .ieee_dav_o(ieee_dav_o),
        .ieee_nrfd_i(ieee_nrfd_i), .ieee_ndac_i(ieee_ndac_i), .ieee_ifc_i(ieee_ifc_i),
        .done(done), .err_timeout(err_timeout), .err_nodev(err_nodev), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Listener script: NRFD goes high from cycle r after accept; NDAC goes high dd
    // cycles after DAV is seen low (dd<0: never), or together with NRFD when early.
    typedef struct {
        logic [7:0] data;
        bit         atn;
        bit         eoi;
        int         r;
        int         dd;
        bit         early;
        bit         rel_mid;
        bit         rel_after;
        int         exp_res;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit m_atn = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input bit a, input bit e, input int r,
                                input int dd, input bit early, input bit rm, input bit ra,
                                input int res);
        vec_t v;
        v.data = d; v.atn = a; v.eoi = e; v.r = r; v.dd = dd;
        v.early = early; v.rel_mid = rm; v.rel_after = ra; v.exp_res = res;
        return v;
    endfunction

    // Cycle numbers relative to the accept cycle (0). A line driven in cycle c is seen
    // by the engine in cycle c+2; WAIT_RFD starts at W; each wait lasts at most T cycles.
    function automatic void model(input int r, input int dd, input bit early,
                                  output int res, output int e, output int f);
        int cr, cd;
        f = -1;
        if (early && r + 2 <= W) begin
            res = RES_NODEV; e = W + 1; return;
        end
        cr = (r + 2 > W) ? r + 2 : W;
        if (cr > W + int'(T) - 1) begin
            res = RES_TMO; e = W + int'(T); return;
        end
        f = cr + 1;
        if (early) cd = f + 1;
        else if (dd < 0) cd = 1 << 30;
        else cd = (f + dd + 2 > f + 1) ? f + dd + 2 : f + 1;
        if (cd > f + int'(T)) begin
            res = RES_TMO; e = f + int'(T) + 1;
        end else begin
            res = RES_DONE; e = cd + 1;
        end
    endfunction

    task automatic run_byte(input vec_t v);
        int res, e, f, fall, n_pulse, pulse_at, kind;
        logic [7:0] exp_d;
        model(v.r, v.dd, v.early, res, e, f);
        exp_d = ~v.data;
        tx_data = v.data; tx_atn = v.atn; tx_eoi = v.eoi; tx_valid = 1'b1;
        ieee_nrfd_i = (v.r <= 0);
        ieee_ndac_i = v.early && (v.r <= 0);
        chk("ready_at_offer", int'(tx_ready), 1);
        @(negedge clk);
        tx_valid = 1'b0;
        m_atn = v.atn;
        chk("dio_setup", int'(ieee_data_o), int'(exp_d));
        chk("eoi_setup", int'(ieee_eoi_o), int'(!v.eoi));
        chk("atn_setup", int'(ieee_atn_o), int'(!m_atn));
        chk("busy_setup", int'(busy), 1);
        fall = -1; n_pulse = 0; pulse_at = -1; kind = -1;
        for (int k = 1; k <= W + 2 * int'(T) + 60; k++) begin
            if (!ieee_dav_o && fall < 0) begin
                fall = k;
                chk("dio_dav", int'(ieee_data_o), int'(exp_d));
            end
            if (done || err_timeout || err_nodev) begin
                n_pulse = int'(done) + int'(err_timeout) + int'(err_nodev);
                pulse_at = k;
                kind = done ? RES_DONE : (err_timeout ? RES_TMO : RES_NODEV);
                break;
            end
            ieee_nrfd_i = (k >= v.r);
            ieee_ndac_i = (v.early && k >= v.r) || (fall >= 0 && v.dd >= 0 && k >= fall + v.dd);
            atn_release = v.rel_mid && (k == 5);
            @(negedge clk);
        end
        atn_release = 1'b0;
        chk("result", kind, v.exp_res);
        chk("pulse_cycle", pulse_at, e);
        chk("dav_fall", fall, f);
        chk("one_pulse", n_pulse, 1);
        chk("dav_released", int'(ieee_dav_o), 1);
        chk("dio_released", int'(ieee_data_o), 8'hFF);
        chk("eoi_released", int'(ieee_eoi_o), 1);
        chk("atn_after", int'(ieee_atn_o), int'(!m_atn));
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(tx_ready), 1);
        chk("no_extra_pulse", int'(done | err_timeout | err_nodev), 0);
        chk("idle_atn", int'(ieee_atn_o), int'(!m_atn));
    endtask

    vec_t vecs[13];

    initial begin
        int res, e, f, k, npl;
        vec_t v;

        vecs[0]  = mk(8'h28, 1, 0, 10, 8, 0, 0, 0, RES_DONE);
        vecs[1]  = mk(8'h41, 1, 0, 10, 8, 0, 1, 0, RES_DONE);
        vecs[2]  = mk(8'h42, 0, 1, 10, 8, 0, 0, 0, RES_DONE);
        vecs[3]  = mk(8'h55, 0, 0, 0, 0, 1, 0, 0, RES_NODEV);
        vecs[4]  = mk(8'h3F, 1, 0, 0, -1, 0, 0, 1, RES_TMO);
        vecs[5]  = mk(8'h60, 0, 0, 1000, 0, 0, 0, 0, RES_TMO);
        vecs[6]  = mk(8'h61, 0, 0, 230, 0, 0, 0, 0, RES_DONE);
        vecs[7]  = mk(8'h62, 0, 0, 231, 0, 0, 0, 0, RES_TMO);
        vecs[8]  = mk(8'h63, 1, 1, 0, 198, 0, 0, 0, RES_DONE);
        vecs[9]  = mk(8'h64, 1, 1, 0, 199, 0, 0, 1, RES_TMO);
        vecs[10] = mk(8'h65, 0, 0, 32, 0, 1, 0, 0, RES_DONE);
        vecs[11] = mk(8'h66, 0, 0, 31, 0, 1, 0, 0, RES_NODEV);
        vecs[12] = mk(8'hC3, 0, 0, 0, 0, 0, 0, 0, RES_DONE);

        reset_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_atn = 1'b0; tx_eoi = 1'b0;
        atn_release = 1'b0; ieee_nrfd_i = 1'b1; ieee_ndac_i = 1'b1; ieee_ifc_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dio", int'(ieee_data_o), 8'hFF);
        chk("rst_atn", int'(ieee_atn_o), 1);
        chk("rst_eoi", int'(ieee_eoi_o), 1);
        chk("rst_dav", int'(ieee_dav_o), 1);
        chk("rst_ready", int'(tx_ready), 0);
        chk("rst_pulses", int'(done | err_timeout | err_nodev), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", int'(tx_ready), 1);

        for (int i = 0; i < 13; i++) begin
            run_byte(vecs[i]);
            if (vecs[i].rel_after) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("atn_held_idle", int'(ieee_atn_o), int'(!m_atn));
                end
                atn_release = 1'b1;
                @(negedge clk);
                atn_release = 1'b0;
                m_atn = 1'b0;
                chk("atn_release", int'(ieee_atn_o), 1);
            end
        end

        // IFC while waiting for NDAC: everything drops, ATN included, no status pulse.
        tx_data = 8'h77; tx_atn = 1'b1; tx_eoi = 1'b0; tx_valid = 1'b1;
        ieee_nrfd_i = 1'b1; ieee_ndac_i = 1'b0;
        @(negedge clk);
        tx_valid = 1'b0; m_atn = 1'b1;
        for (int j = 0; j < 100 && ieee_dav_o; j++) @(negedge clk);
        chk("ifc_dav_low", int'(ieee_dav_o), 0);
        repeat (3) @(negedge clk);
        npl = 0;
        ieee_ifc_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            npl += int'(done) + int'(err_timeout) + int'(err_nodev);
        end
        m_atn = 1'b0;
        chk("ifc_dav", int'(ieee_dav_o), 1);
        chk("ifc_dio", int'(ieee_data_o), 8'hFF);
        chk("ifc_atn", int'(ieee_atn_o), 1);
        chk("ifc_eoi", int'(ieee_eoi_o), 1);
        chk("ifc_busy", int'(busy), 0);
        repeat (4) begin
            @(negedge clk);
            npl += int'(done) + int'(err_timeout) + int'(err_nodev);
            chk("ifc_ready_low", int'(tx_ready), 0);
        end
        ieee_ifc_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("ifc_ready_lag", int'(tx_ready), 0);
        @(negedge clk);
        chk("ifc_ready_back", int'(tx_ready), 1);
        chk("ifc_no_pulse", npl, 0);

        // Reset asserted while DAV has just fallen: lines release without a clock.
        tx_data = 8'h99; tx_atn = 1'b1; tx_eoi = 1'b1; tx_valid = 1'b1;
        ieee_nrfd_i = 1'b1; ieee_ndac_i = 1'b0;
        @(negedge clk);
        tx_valid = 1'b0;
        k = 1;
        while (ieee_dav_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rstmid_fall", k, W + 1);
        reset_n = 1'b0;
        #1;
        m_atn = 1'b0;
        chk("rstmid_dav", int'(ieee_dav_o), 1);
        chk("rstmid_dio", int'(ieee_data_o), 8'hFF);
        chk("rstmid_atn", int'(ieee_atn_o), 1);
        chk("rstmid_eoi", int'(ieee_eoi_o), 1);
        chk("rstmid_ready", int'(tx_ready), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_byte(mk(8'h5A, 0, 1, 10, 8, 0, 0, 0, RES_DONE));

        for (int i = 0; i < 16; i++) begin
            v.data = 8'($urandom);
            v.atn = 1'($urandom);
            v.eoi = 1'($urandom);
            v.early = ($urandom_range(0, 3) == 0);
            v.r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(225, 240)) : int'($urandom_range(0, 60));
            case ($urandom_range(0, 7))
                0: v.dd = -1;
                1: v.dd = int'($urandom_range(195, 205));
                default: v.dd = int'($urandom_range(0, 30));
            endcase
            v.rel_mid = 1'($urandom);
            v.rel_after = 1'b0;
            model(v.r, v.dd, v.early, res, e, f);
            v.exp_res = res;
            run_byte(v);
            if ($urandom_range(0, 2) == 0) begin
                atn_release = 1'b1;
                @(negedge clk);
                atn_release = 1'b0;
                m_atn = 1'b0;
                chk("rand_atn_release", int'(ieee_atn_o), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
